// File: rtl/mac_accum_pipe.sv
// mac_accum_pipe: pipelined unsigned multiply-accumulate with up/down mode,
// per-operation clear, valid tagging, saturate or wrap arithmetic and a
// sticky overflow flag. One operand pair per cycle, no backpressure.
module mac_accum_pipe #(
  parameter int A_W      = 8,
  parameter int B_W      = 8,
  parameter int ACC_W    = 20,
  parameter int IN_REGS  = 2,
  parameter bit SATURATE = 1'b1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic             up_down,
  input  logic             clear,
  output logic [ACC_W-1:0] acc,
  output logic             out_valid,
  output logic             ovf
);

  localparam int P_W = A_W + B_W;
  localparam int S_W = ACC_W + 1;

  generate
    if (ACC_W < P_W) begin : g_bad_acc_w
      $error("mac_accum_pipe: ACC_W must be >= A_W+B_W");
    end
    if ((IN_REGS < 1) || (IN_REGS > 4)) begin : g_bad_in_regs
      $error("mac_accum_pipe: IN_REGS must be in 1..4");
    end
  endgenerate

  // input stages: operation fields travel together
  logic           stg_vld_r [IN_REGS];
  logic [A_W-1:0] stg_a_r   [IN_REGS];
  logic [B_W-1:0] stg_b_r   [IN_REGS];
  logic           stg_up_r  [IN_REGS];
  logic           stg_clr_r [IN_REGS];

  // product stage
  logic           p_vld_r;
  logic [P_W-1:0] p_r;
  logic           p_up_r;
  logic           p_clr_r;

  // operands staged for the accumulator so the add/compare starts from a register
  logic           q_vld_r;
  logic [P_W-1:0] q_p_r;
  logic           q_up_r;
  logic           q_clr_r;

  // accumulator outputs
  logic [ACC_W-1:0] acc_r;
  logic             ovf_r;
  logic             out_vld_r;

  // next-state of the accumulate stage
  logic [S_W-1:0]   base_s;
  logic [S_W-1:0]   p_ext_s;
  logic [S_W-1:0]   sum_s;
  logic             hit_s;
  logic [ACC_W-1:0] acc_nxt_s;
  logic             ovf_nxt_s;
  logic [P_W-1:0]   mul_s;

  assign mul_s = P_W'(stg_a_r[IN_REGS-1]) * P_W'(stg_b_r[IN_REGS-1]);

  // shift the input stages; stage 0 samples the ports every cycle
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < IN_REGS; i++) begin
        stg_vld_r[i] <= 1'b0;
        stg_a_r[i]   <= '0;
        stg_b_r[i]   <= '0;
        stg_up_r[i]  <= 1'b0;
        stg_clr_r[i] <= 1'b0;
      end
    end else begin
      stg_vld_r[0] <= in_valid;
      stg_a_r[0]   <= a;
      stg_b_r[0]   <= b;
      stg_up_r[0]  <= up_down;
      stg_clr_r[0] <= clear;
      for (int i = 1; i < IN_REGS; i++) begin
        stg_vld_r[i] <= stg_vld_r[i-1];
        stg_a_r[i]   <= stg_a_r[i-1];
        stg_b_r[i]   <= stg_b_r[i-1];
        stg_up_r[i]  <= stg_up_r[i-1];
        stg_clr_r[i] <= stg_clr_r[i-1];
      end
    end
  end

  // register the exact product, then stage it for the accumulator
  always_ff @(posedge CLK) begin
    if (reset) begin
      p_vld_r <= 1'b0;
      p_r     <= '0;
      p_up_r  <= 1'b0;
      p_clr_r <= 1'b0;
      q_vld_r <= 1'b0;
      q_p_r   <= '0;
      q_up_r  <= 1'b0;
      q_clr_r <= 1'b0;
    end else begin
      p_vld_r <= stg_vld_r[IN_REGS-1];
      p_r     <= mul_s;
      p_up_r  <= stg_up_r[IN_REGS-1];
      p_clr_r <= stg_clr_r[IN_REGS-1];
      q_vld_r <= p_vld_r;
      q_p_r   <= p_r;
      q_up_r  <= p_up_r;
      q_clr_r <= p_clr_r;
    end
  end

  // one extra bit of headroom exposes both overflow (carry) and underflow
  always_comb begin
    base_s    = '0;
    p_ext_s   = S_W'(q_p_r);
    sum_s     = '0;
    hit_s     = 1'b0;
    acc_nxt_s = '0;
    ovf_nxt_s = 1'b0;
    if (q_clr_r) begin
      base_s = '0;
    end else begin
      base_s = {1'b0, acc_r};
    end
    if (q_up_r) begin
      sum_s = base_s + p_ext_s;
      hit_s = sum_s[ACC_W];
    end else begin
      sum_s = base_s - p_ext_s;
      hit_s = (p_ext_s > base_s);
    end
    if (hit_s && SATURATE) begin
      if (q_up_r) begin
        acc_nxt_s = {ACC_W{1'b1}};
      end else begin
        acc_nxt_s = '0;
      end
    end else begin
      acc_nxt_s = sum_s[ACC_W-1:0];
    end
    // a clearing operation restarts the sticky flag from its own result
    if (q_clr_r) begin
      ovf_nxt_s = hit_s;
    end else begin
      ovf_nxt_s = ovf_r | hit_s;
    end
  end

  // accumulator, sticky flag and valid pulse; bubbles hold acc and ovf
  always_ff @(posedge CLK) begin
    if (reset) begin
      acc_r     <= '0;
      ovf_r     <= 1'b0;
      out_vld_r <= 1'b0;
    end else begin
      out_vld_r <= q_vld_r;
      if (q_vld_r) begin
        acc_r <= acc_nxt_s;
        ovf_r <= ovf_nxt_s;
      end else begin
        acc_r <= acc_r;
        ovf_r <= ovf_r;
      end
    end
  end

  assign acc       = acc_r;
  assign ovf       = ovf_r;
  assign out_valid = out_vld_r;

endmodule
